reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   Register file for the pipeline decode stage, directly downstream of the
//   single Register cell. Holds NUM_REGS x DATA_W words.
//   Provides two combinational read ports and one clocked write port.
//   R0 is hardwired to zero. Tracks which registers have been written since reset.
// PARAMETERS
//   NUM_REGS  16  number of architectural registers (power of 2, >= 2)
//   DATA_W    16  word width in bits
//   ADDR_W    4   register index width; must equal $clog2(NUM_REGS)
// PORTS
//   clk       in   1         clock; all state updates on posedge
//   rst       in   1         synchronous, active-high reset
//   SrcReg1   in   ADDR_W    read port 1 register index
//   SrcReg2   in   ADDR_W    read port 2 register index
//   DstReg    in   ADDR_W    write port register index
//   WriteReg  in   1         write enable; DstData is stored into DstReg at posedge
//   DstData   in   DATA_W    write data
//   SrcData1  out  DATA_W    read data, port 1
//   SrcData2  out  DATA_W    read data, port 2
//   Written   out  NUM_REGS  bit i = 1 once reg i has been written since last reset
// BEHAVIOUR
// - Reset: rst sampled high at posedge clears all registers to 0 and clears Written to 0.
//   Reset has priority over a simultaneous WriteReg; that write is discarded.
// - While rst is high, SrcData1 and SrcData2 are forced to 0.
//   Reset value of every output is 0.
// - Write: WriteReg=1 and rst=0 at posedge stores DstData into reg[DstReg].
//   The same edge sets Written[DstReg]. Written bits stay set until rst.
// - R0: writes to DstReg=0 are ignored; Written[0] is never set.
//   Reads of index 0 return 0 in all modes.
// - Read: SrcDataN = reg[SrcRegN], combinational, 0-cycle latency from SrcRegN.
//   Outputs are always driven; they never go high-Z.
// - Both read ports may address the same register, including DstReg.
//   Both then return identical data.
// - Rewriting the same register on back-to-back cycles is allowed; the last write wins.
// - Reset mid-sequence: a write pending on the reset edge is lost.
//   The first post-reset write takes effect normally.
// - No state machine. State consists of the register array and the Written vector.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     If WriteReg=1, rst=0, DstReg!=0 and DstReg==SrcRegN, then SrcDataN = DstData
//     combinationally in the same cycle (write-before-read). Otherwise reads come
//     from the stored array.
//   REGFILE_BYPASS_EN undefined:
//     Reads always return the stored value. A write becomes visible on the read
//     ports the cycle after its posedge.
// TESTING
// 1 Reset: hold rst for 2 cycles with WriteReg=1, DstReg=3, DstData=16'hBEEF
//   -> every reg reads 0, Written=0, SrcData1/2=0 throughout.
// 2 Write/read: write 16'hFFFF to R5, then read SrcReg1=SrcReg2=5 next cycle
//   -> both ports = 16'hFFFF, Written=16'h0020.
// 3 R0: write 16'h1234 to R0, then read R0 on both ports
//   -> both ports = 16'h0000, Written[0]=0.
// 4 Bypass: in one cycle set WriteReg=1, DstReg=7, DstData=16'hA5A5, SrcReg1=7
//   -> with _EN, SrcData1=16'hA5A5 in that cycle.
//   -> without _EN, SrcData1=old R7 value, then 16'hA5A5 after the posedge.
// 5 Back-to-back: write 16'h0001, then 16'h0002 to R15 on consecutive cycles, then read
//   -> 16'h0002; other regs unchanged.
// 6 Reset mid-op: fill R1..R15 with their index; assert rst one cycle with a write to R2
//   -> all regs read 0 and Written=0 after the edge.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_W register file, two combinational read ports, one write port, R0 reads zero.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   SrcReg1,
  input  logic [ADDR_W-1:0]   SrcReg2,
  input  logic [ADDR_W-1:0]   DstReg,
  input  logic                WriteReg,
  input  logic [DATA_W-1:0]   DstData,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  output logic [NUM_REGS-1:0] Written
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  // R0 is never written, so its storage stays at the reset value of zero
  assign wr_en = WriteReg && (DstReg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      Written <= '0;
    end else if (wr_en) begin
      regs[DstReg]    <= DstData;
      Written[DstReg] <= 1'b1;
    end
  end

  always_comb begin
    SrcData1 = regs[SrcReg1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (DstReg == SrcReg1)) begin
      SrcData1 = DstData;
    end
`endif
    if (rst || (SrcReg1 == '0)) begin
      SrcData1 = '0;
    end
  end

  always_comb begin
    SrcData2 = regs[SrcReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (DstReg == SrcReg2)) begin
      SrcData2 = DstData;
    end
`endif
    if (rst || (SrcReg2 == '0)) begin
      SrcData2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus random checking of reg_file against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;
  logic [15:0] Written;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [16];
  logic [15:0] ref_written;

  reg_file #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .DstReg(DstReg),
    .WriteReg(WriteReg), .DstData(DstData), .SrcData1(SrcData1), .SrcData2(SrcData2),
    .Written(Written)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(logic [3:0] idx);
    if (rst || idx == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (WriteReg && DstReg != 4'd0 && DstReg == idx) return DstData;
`endif
    return ref_mem[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    ref_written = 16'h0000;
  endtask

  // check outputs for the current inputs, then clock once and update the model
  task automatic cycle(string tag);
    #1;
    check({tag, ":rd1"}, SrcData1, exp_read(SrcReg1));
    check({tag, ":rd2"}, SrcData2, exp_read(SrcReg2));
    check({tag, ":written"}, Written, ref_written);
    @(posedge clk);
    if (rst) model_clear();
    else if (WriteReg && DstReg != 4'd0) begin
      ref_mem[DstReg] = DstData;
      ref_written[DstReg] = 1'b1;
    end
    #1;
  endtask

  task automatic read_all(string tag);
    rst = 1'b0;
    WriteReg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(15 - i);
      #1;
      check({tag, ":all1"}, SrcData1, exp_read(SrcReg1));
      check({tag, ":all2"}, SrcData2, exp_read(SrcReg2));
    end
    check({tag, ":allw"}, Written, ref_written);
  endtask

  task automatic wr(logic [3:0] d, logic [15:0] v, string tag);
    rst = 1'b0; WriteReg = 1'b1; DstReg = d; DstData = v;
    cycle(tag);
    WriteReg = 1'b0;
  endtask

  initial begin
    // 1: reset held two edges with a competing write
    rst = 1'b1; WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'hBEEF;
    SrcReg1 = 4'd3; SrcReg2 = 4'd0;
    model_clear();
    @(posedge clk); #1;
    cycle("reset");
    read_all("reset");
    check("reset:w0", Written, 16'h0000);

    // 2: write/read R5
    wr(4'd5, 16'hFFFF, "wr5");
    SrcReg1 = 4'd5; SrcReg2 = 4'd5; #1;
    check("wr5:p1", SrcData1, 16'hFFFF);
    check("wr5:p2", SrcData2, 16'hFFFF);
    check("wr5:w", Written, 16'h0020);

    // 3: R0 ignored
    wr(4'd0, 16'h1234, "r0");
    SrcReg1 = 4'd0; SrcReg2 = 4'd0; #1;
    check("r0:p1", SrcData1, 16'h0000);
    check("r0:p2", SrcData2, 16'h0000);
    check("r0:w0", 32'(Written[0]), 32'd0);

    // 4: write and read R7 in the same cycle
    wr(4'd7, 16'h1111, "r7pre");
    rst = 1'b0; WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'hA5A5;
    SrcReg1 = 4'd7; SrcReg2 = 4'd7; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp:same", SrcData1, 16'hA5A5);
`else
    check("byp:old", SrcData1, 16'h1111);
`endif
    cycle("byp");
    WriteReg = 1'b0; #1;
    check("byp:after", SrcData1, 16'hA5A5);

    // 5: back-to-back writes to R15
    wr(4'd15, 16'h0001, "b2b1");
    wr(4'd15, 16'h0002, "b2b2");
    SrcReg1 = 4'd15; #1;
    check("b2b:last", SrcData1, 16'h0002);
    read_all("b2b");

    // 6: fill R1..R15, then reset with a write to R2 pending
    for (int i = 1; i < 16; i++) wr(4'(i), 16'(i), "fill");
    read_all("fill");
    rst = 1'b1; WriteReg = 1'b1; DstReg = 4'd2; DstData = 16'hDEAD;
    cycle("midrst");
    read_all("midrst");
    check("midrst:w", Written, 16'h0000);
    wr(4'd2, 16'h5555, "postrst");
    SrcReg1 = 4'd2; #1;
    check("postrst:r2", SrcData1, 16'h5555);

    // random traffic, occasional reset and forced read/write address collisions
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      WriteReg = 1'($urandom_range(0, 1));
      DstReg   = 4'($urandom_range(0, 15));
      DstData  = 16'($urandom);
      SrcReg1  = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom_range(0, 15));
      SrcReg2  = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom_range(0, 15));
      cycle("rand");
    end
    read_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
